ghost_catch: RTL and testbench
==============================

GHOST_CATCH -- requirements
Module: ghost_catch

Interface
REQ-001 Parameter HIT_DIST, default 8, overlap threshold in pixels per axis.
REQ-002 Parameter FREEZE_TICKS, default 60, length of the post-catch freeze in ticks.
REQ-003 Parameter LIVES_INIT, default 3 (range 1..3), lives loaded at game start.
REQ-004 clk  input  1  system clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous, active-low reset (0 = reset).
REQ-006 tick  input  1  one-clk-wide movement strobe, shared with the sprite movers.
REQ-007 start  input  1  level; requests game start or restart.
REQ-008 pac_x  input  10  Pac-Man X position.
REQ-009 pac_y  input  9  Pac-Man Y position.
REQ-010 ghost_x  input  10  ghost X position.
REQ-011 ghost_y  input  9  ghost Y position.
REQ-012 caught  output  1  one-clk pulse per registered catch.
REQ-013 lives  output  2  remaining lives.
REQ-014 game_state  output  2  current FSM state encoding.
REQ-015 freeze  output  1  high = movers must hold position.
REQ-016 game_over  output  1  high while in OVER.

Function
REQ-017 FSM states: IDLE=0, PLAY=1, FREEZE=2, OVER=3; game_state reflects the registered state.
REQ-018 Hit = (|pac_x-ghost_x| < HIT_DIST) AND (|pac_y-ghost_y| < HIT_DIST); differences computed at 11/10 bits unsigned-magnitude, no wrap-around.
REQ-019 IDLE: start=1 -> PLAY next cycle, lives <= LIVES_INIT.
REQ-020 PLAY: hit sampled only in cycles with tick=1; on hit, caught=1 in the next cycle and lives decrements in that same cycle.
REQ-021 PLAY on hit: lives==1 -> OVER, lives==0 output; otherwise -> FREEZE, freeze counter <= FREEZE_TICKS.
REQ-022 FREEZE: freeze=1; counter decrements once per tick; -> PLAY in the cycle after the tick that makes the counter 0; hits are ignored.
REQ-023 OVER: freeze=1, game_over=1; start=1 -> PLAY, lives <= LIVES_INIT.
REQ-024 start is ignored in PLAY and FREEZE.
REQ-025 If start and tick coincide in OVER or IDLE, start wins; no hit is evaluated that cycle.
REQ-026 lives never wraps below 0; caught never asserts in consecutive cycles.
REQ-027 freeze=0 in IDLE and PLAY.

Reset
REQ-028 On rst=0 at a clk edge: state=IDLE, lives=0, caught=0, freeze=0, game_over=0, freeze counter=0, invulnerability counter=0.
REQ-029 Reset asserted mid-FREEZE or mid-OVER takes effect at the next edge, with no caught pulse.

Configuration
REQ-030 Macro GHOST_CATCH_INVULN_EN defined: on the FREEZE->PLAY transition, a 6-bit counter loads 32; it decrements per tick in PLAY, and hits are ignored while it is non-zero.
REQ-031 Macro undefined: no invulnerability counter; hits count from the first tick in PLAY.

Structure
REQ-032 Shared package ghost_pkg holds the game_state typedef/encoding and the constants X_W=10, Y_W=9, HIT_DIST default.
REQ-033 One sub-module, coord_dist, computes the per-axis absolute difference and the below-threshold flag; it is instantiated twice (X, Y).

Verification
REQ-034 rst=0 for 2 cycles, then start=1 -> state PLAY, lives=3, freeze=0.
REQ-035 PLAY, pac=(100,100), ghost=(105,95), tick -> caught pulse 1 cycle later, lives=2, state FREEZE, freeze=1; 60 ticks later -> PLAY.
REQ-036 PLAY, pac=(100,100), ghost=(108,100), tick -> no catch (boundary dx=8); ghost=(107,100) -> catch.
REQ-037 Three catches from lives=3 -> lives=0, game_over=1, state OVER; start=1 -> PLAY, lives=3.
REQ-038 With GHOST_CATCH_INVULN_EN: overlap held after FREEZE exits -> no catch for 32 ticks, catch on tick 33; without the macro -> catch on the first tick.
REQ-039 rst=0 asserted mid-FREEZE -> next cycle IDLE, lives=0, freeze=0, no caught pulse.

Source files
------------

// File: rtl/ghost_pkg.sv
// Shared definitions for the ghost_catch game-logic block.
// Contents: coordinate widths, default overlap threshold, invulnerability
// window length and the game FSM state encoding (also driven on game_state).
package ghost_pkg;

  localparam int unsigned X_W              = 10;
  localparam int unsigned Y_W              = 9;
  localparam int unsigned HIT_DIST_DEFAULT = 8;
  localparam int unsigned INVULN_TICKS     = 32;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StPlay   = 2'd1,
    StFreeze = 2'd2,
    StOver   = 2'd3
  } game_state_e;

endpackage

// File: rtl/ghost_catch_if.sv
// Signal bundle between the game controller and the ghost_catch block.
// master: drives tick/start/positions, observes caught/lives/game_state/freeze/game_over.
// slave : the ghost_catch block itself.
interface ghost_catch_if;
  import ghost_pkg::*;

  logic           tick;
  logic           start;
  logic [X_W-1:0] pac_x;
  logic [Y_W-1:0] pac_y;
  logic [X_W-1:0] ghost_x;
  logic [Y_W-1:0] ghost_y;
  logic           caught;
  logic [1:0]     lives;
  logic [1:0]     game_state;
  logic           freeze;
  logic           game_over;

  modport master (
    output tick, start, pac_x, pac_y, ghost_x, ghost_y,
    input  caught, lives, game_state, freeze, game_over
  );

  modport slave (
    input  tick, start, pac_x, pac_y, ghost_x, ghost_y,
    output caught, lives, game_state, freeze, game_over
  );

endinterface

// File: rtl/coord_dist.sv
// Per-axis proximity test: |a_i - b_i| < Dist.
// Ports: a_i, b_i  - W-bit unsigned coordinates
//        near_o    - high when the absolute difference is below Dist
module coord_dist #(
  parameter int unsigned W    = 10,
  parameter int unsigned Dist = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         near_o
);

  localparam logic [W:0] DistW = (W + 1)'(Dist);

  logic [W:0] a_ext;
  logic [W:0] b_ext;
  logic [W:0] diff;

  assign a_ext = {1'b0, a_i};
  assign b_ext = {1'b0, b_i};

  // Subtract the smaller from the larger so the magnitude never wraps.
  always_comb begin
    if (a_ext >= b_ext) diff = a_ext - b_ext;
    else                diff = b_ext - a_ext;
  end

  assign near_o = (diff < DistW);

endmodule

// File: rtl/ghost_catch.sv
// Pac-Man / ghost collision and lives controller.
// Ports: clk  - system clock (rising edge)
//        rst  - synchronous active-low reset
//        bus  - ghost_catch_if.slave: tick, start, positions in; caught, lives,
//               game_state, freeze, game_over out
// Optional feature: define GHOST_CATCH_INVULN_EN to ignore hits for 32 ticks
// after every freeze ends.
module ghost_catch import ghost_pkg::*; #(
  parameter int unsigned HIT_DIST     = HIT_DIST_DEFAULT,
  parameter int unsigned FREEZE_TICKS = 60,
  parameter int unsigned LIVES_INIT   = 3
) (
  input logic          clk,
  input logic          rst,
  ghost_catch_if.slave bus
);

  localparam int unsigned  FcW        = (FREEZE_TICKS > 1) ? $clog2(FREEZE_TICKS + 1) : 1;
  localparam logic [FcW-1:0] FreezeLoad = FcW'(FREEZE_TICKS);
  localparam logic [1:0]   LivesLoad  = 2'(LIVES_INIT);

  game_state_e    state_q, state_d;
  logic [1:0]     lives_q, lives_d;
  logic [FcW-1:0] fcnt_q, fcnt_d;
  logic           caught_q, caught_d;
  logic           near_x, near_y, hit, armed;

  coord_dist #(.W(X_W), .Dist(HIT_DIST)) u_dist_x (
    .a_i    (bus.pac_x),
    .b_i    (bus.ghost_x),
    .near_o (near_x)
  );

  coord_dist #(.W(Y_W), .Dist(HIT_DIST)) u_dist_y (
    .a_i    (bus.pac_y),
    .b_i    (bus.ghost_y),
    .near_o (near_y)
  );

  assign hit = near_x & near_y;

`ifdef GHOST_CATCH_INVULN_EN
  logic [5:0] inv_q, inv_d;
  assign armed = (inv_q == 6'd0);
`else
  assign armed = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    lives_d  = lives_q;
    fcnt_d   = fcnt_q;
    caught_d = 1'b0;
`ifdef GHOST_CATCH_INVULN_EN
    inv_d    = inv_q;
`endif
    unique case (state_q)
      // start takes priority over tick here: no hit is evaluated in these states.
      StIdle, StOver: begin
        if (bus.start) begin
          state_d = StPlay;
          lives_d = LivesLoad;
`ifdef GHOST_CATCH_INVULN_EN
          inv_d   = 6'd0;
`endif
        end
      end
      StPlay: begin
        if (bus.tick) begin
          if (!armed) begin
`ifdef GHOST_CATCH_INVULN_EN
            inv_d = inv_q - 6'd1;
`endif
          end else if (hit) begin
            caught_d = 1'b1;
            lives_d  = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
            if (lives_q <= 2'd1) begin
              state_d = StOver;
            end else begin
              state_d = StFreeze;
              fcnt_d  = FreezeLoad;
            end
          end
        end
      end
      StFreeze: begin
        if (bus.tick) begin
          if (fcnt_q <= FcW'(1)) begin
            fcnt_d  = '0;
            state_d = StPlay;
`ifdef GHOST_CATCH_INVULN_EN
            inv_d   = 6'(INVULN_TICKS);
`endif
          end else begin
            fcnt_d = fcnt_q - FcW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      lives_q  <= 2'd0;
      fcnt_q   <= '0;
      caught_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lives_q  <= lives_d;
      fcnt_q   <= fcnt_d;
      caught_q <= caught_d;
    end
  end

`ifdef GHOST_CATCH_INVULN_EN
  always_ff @(posedge clk) begin
    if (!rst) inv_q <= 6'd0;
    else      inv_q <= inv_d;
  end
`endif

  assign bus.caught     = caught_q;
  assign bus.lives      = lives_q;
  assign bus.game_state = state_q;
  assign bus.freeze     = (state_q == StFreeze) || (state_q == StOver);
  assign bus.game_over  = (state_q == StOver);

endmodule

// File: tb/tb_ghost_catch.sv
module tb_ghost_catch;

  localparam int HitDist = 8;
  localparam int FreezeT = 60;
  localparam int LivesI  = 3;
`ifdef GHOST_CATCH_INVULN_EN
  localparam int FirstCatchTick = 33;
`else
  localparam int FirstCatchTick = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ghost_catch_if bus ();

  ghost_catch #(
    .HIT_DIST     (HitDist),
    .FREEZE_TICKS (FreezeT),
    .LIVES_INIT   (LivesI)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: game rules in plain integers.
  // m_st: 0 idle, 1 play, 2 freeze, 3 over.
  int m_st = 0, m_lives = 0, m_fz = 0, m_inv = 0;
  int m_caught = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit overlap();
    int dx, dy;
    dx = int'(bus.pac_x) - int'(bus.ghost_x);
    dy = int'(bus.pac_y) - int'(bus.ghost_y);
    if (dx < 0) dx = -dx;
    if (dy < 0) dy = -dy;
    return (dx < HitDist) && (dy < HitDist);
  endfunction

  task automatic model_edge();
    m_caught = 0;
    if (!rst) begin
      m_st = 0; m_lives = 0; m_fz = 0; m_inv = 0;
    end else if (m_st == 0 || m_st == 3) begin
      if (bus.start) begin m_st = 1; m_lives = LivesI; end
    end else if (m_st == 1) begin
      if (bus.tick) begin
        if (m_inv > 0) m_inv--;
        else if (overlap()) begin
          m_caught = 1;
          if (m_lives > 0) m_lives--;
          if (m_lives == 0) m_st = 3;
          else begin m_st = 2; m_fz = FreezeT; end
        end
      end
    end else begin
      if (bus.tick) begin
        m_fz--;
        if (m_fz == 0) begin
          m_st = 1;
`ifdef GHOST_CATCH_INVULN_EN
          m_inv = 32;
`endif
        end
      end
    end
  endtask

  // One clock: advance model at the edge, compare all outputs just after it.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check("state", int'(bus.game_state), m_st);
    check("lives", int'(bus.lives), m_lives);
    check("caught", int'(bus.caught), m_caught);
    check("freeze", int'(bus.freeze), (m_st >= 2) ? 1 : 0);
    check("game_over", int'(bus.game_over), (m_st == 3) ? 1 : 0);
  endtask

  task automatic set_pos(input int px, input int py, input int gx, input int gy);
    bus.pac_x   = 10'(px);
    bus.pac_y   = 9'(py);
    bus.ghost_x = 10'(gx);
    bus.ghost_y = 9'(gy);
  endtask

  task automatic tick_cyc();
    bus.tick = 1'b1;
    cyc();
    bus.tick = 1'b0;
  endtask

  // Ticks (every other cycle) until freeze ends; returns ticks used.
  task automatic run_freeze(output int n);
    n = 0;
    while (n < 200) begin
      tick_cyc();
      n++;
      if (bus.game_state == 2'd1) break;
      cyc();
    end
  endtask

  // Ticks until a caught pulse is seen; returns ticks used.
  task automatic run_to_catch(output int n);
    n = 0;
    while (n < 200) begin
      tick_cyc();
      n++;
      if (bus.caught) break;
      cyc();
    end
  endtask

  initial begin
    int n, px, py, gx, gy;
    bus.tick  = 1'b0;
    bus.start = 1'b0;
    set_pos(0, 0, 500, 300);

    // Reset for two cycles.
    rst = 1'b0;
    cyc();
    cyc();
    check("rst_state", int'(bus.game_state), 0);
    check("rst_lives", int'(bus.lives), 0);

    rst = 1'b1;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    check("start_state", int'(bus.game_state), 1);
    check("start_lives", int'(bus.lives), 3);
    check("start_freeze", int'(bus.freeze), 0);

    // dx = 8 is just outside the threshold.
    set_pos(100, 100, 108, 100);
    tick_cyc();
    check("bnd8_caught", int'(bus.caught), 0);
    set_pos(100, 100, 107, 100);
    tick_cyc();
    check("bnd7_caught", int'(bus.caught), 1);
    check("bnd7_lives", int'(bus.lives), 2);
    check("bnd7_state", int'(bus.game_state), 2);
    cyc();
    check("pulse_len", int'(bus.caught), 0);

    // Overlap is held through the freeze and after it.
    set_pos(100, 100, 100, 100);
    run_freeze(n);
    check("freeze_ticks1", n, FreezeT);
    run_to_catch(n);
    check("first_catch1", n, FirstCatchTick);
    check("lives_after2", int'(bus.lives), 1);
    run_freeze(n);
    check("freeze_ticks2", n, FreezeT);
    run_to_catch(n);
    check("first_catch2", n, FirstCatchTick);
    check("over_lives", int'(bus.lives), 0);
    check("over_go", int'(bus.game_over), 1);
    check("over_state", int'(bus.game_state), 3);
    repeat (3) tick_cyc();

    // start and tick together in OVER: start wins, no catch evaluated.
    bus.start = 1'b1;
    tick_cyc();
    bus.start = 1'b0;
    check("restart_state", int'(bus.game_state), 1);
    check("restart_lives", int'(bus.lives), 3);
    check("restart_caught", int'(bus.caught), 0);

    // Diagonal overlap.
    set_pos(100, 100, 105, 95);
    tick_cyc();
    check("diag_caught", int'(bus.caught), 1);
    check("diag_lives", int'(bus.lives), 2);
    check("diag_freeze", int'(bus.freeze), 1);
    repeat (5) tick_cyc();

    // Reset mid-freeze.
    rst = 1'b0;
    cyc();
    check("midrst_state", int'(bus.game_state), 0);
    check("midrst_lives", int'(bus.lives), 0);
    check("midrst_freeze", int'(bus.freeze), 0);
    check("midrst_caught", int'(bus.caught), 0);
    rst = 1'b1;

    // Randomized play against the model.
    for (int i = 0; i < 8000; i++) begin
      rst       = ($urandom_range(599) != 0);
      bus.start = ($urandom_range(29) == 0);
      bus.tick  = ($urandom_range(1) == 0);
      px = $urandom_range(1023);
      py = $urandom_range(511);
      if ($urandom_range(3) != 0) begin
        gx = px + $urandom_range(24) - 12;
        gy = py + $urandom_range(24) - 12;
        if (gx < 0) gx = 0;
        if (gx > 1023) gx = 1023;
        if (gy < 0) gy = 0;
        if (gy > 511) gy = 511;
      end else begin
        gx = $urandom_range(1023);
        gy = $urandom_range(511);
      end
      set_pos(px, py, gx, gy);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
